fb_pixel_writer: RTL and testbench
==================================

# fb_pixel_writer

Receiving end of the pixel-plot stream that the sprite and background drawers emit (x, y, color, plot). Accepts one pixel per cycle into a small FIFO, converts screen coordinates to a linear framebuffer address (y·160 + x), and issues writes to the framebuffer memory port. Writes are completed only when the memory arbiter grants them. The block sits between all drawing engines and the VGA framebuffer RAM.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  8  pixel column, 0..159 valid.
- y  in  7  pixel row, 0..119 valid.
- color  in  3  RGB pixel colour.
- plot  in  1  pixel valid; accepted on a rising edge where plot && ready.
- ready  out  1  high when the FIFO is not full.
- mem_addr  out  15  framebuffer word address.
- mem_data  out  3  colour to write.
- mem_we  out  1  write request; held with address and data stable until granted.
- mem_gnt  in  1  arbiter grant; a write completes on an edge where mem_we && mem_gnt.
- idle  out  1  high when the FIFO and the output stage are both empty.
- drop_count  out  8  count of clipped pixels, saturating.

## Operation
- Input side: on an accept edge, {x, y, color} is pushed into the FIFO. Exception: a pixel clipped under PIXEL_CLIP_EN is not stored.
- ready = !full. It is derived from the registered occupancy count. It stays low when full, even on a cycle where an entry drains.
- Output stage: a single register holding {mem_addr, mem_data}, with mem_we as its valid bit.
  - It loads from the FIFO head when the stage is empty, or is completing a write this edge, and the FIFO is non-empty.
  - On the same edge it pops the FIFO.
- Address arithmetic: mem_addr = y·160 + x, computed as (y<<7) + (y<<5) + x. Use a 15-bit result; the maximum valid value is 19199.
- Simultaneous push and pop: occupancy is unchanged, and the head/tail pointers both advance modulo DEPTH.
- mem_we deasserts only after a granted edge that leaves the FIFO empty.
- mem_gnt is ignored while mem_we is low.
- idle = (occupancy == 0) && !mem_we.

## Timing
- Reset values:
  - mem_we = 0, mem_addr = 0, mem_data = 0.
  - ready = 1, idle = 1, drop_count = 0.
  - FIFO is empty.
- Reset is asynchronous: the FIFO is flushed, any pending write is dropped, and mem_we goes low immediately. No partial write is retried after release.
- Latency: a pixel accepted at edge N, with the stage empty and the FIFO empty, appears with mem_we high after edge N+1.
- Throughput: with mem_gnt held high, one write completes per cycle. ready never drops.
- Back-pressure: with mem_gnt low, DEPTH further pixels are accepted after the stage fills, then ready falls.

## Configuration
- PIXEL_CLIP_EN defined:
  - A pixel with x ≥ 160 or y ≥ 120 is still accepted (it consumes a plot handshake) but is discarded.
  - drop_count increments by 1 per discarded pixel and saturates at 255.
  - Clipping does not affect ready.
- PIXEL_CLIP_EN undefined:
  - All pixels are stored. The address is truncated to 15 bits with no range check.
  - drop_count is tied to 0.

## Structure
- Shared package fb_pkg holds:
  - SCREEN_W = 160, SCREEN_H = 120.
  - ADDR_W = 15, COLOR_W = 3.
  - A packed pixel_t {x[7:0], y[6:0], color[2:0]}.
- The drawing engines reuse fb_pkg.
- Sub-module pixel_fifo: a parameterised synchronous FIFO of pixel_t. It provides push, pop, full, empty and count, with async active-high reset.
- The top level holds the clip check, the address computation and the output register.

## Test plan
- Single pixel: plot x=5, y=2, color=3'b101, mem_gnt=1. mem_we rises after the second edge with mem_addr=325 and mem_data=5. After the write, idle returns to 1.
- Corner address: x=159, y=119 gives mem_addr=19199. x=0, y=0 gives mem_addr=0.
- Back-pressure, DEPTH=4: hold mem_gnt=0 and plot continuously. Exactly 5 pixels are accepted, then ready=0 and mem_we is held with the first pixel stable. Then release mem_gnt for 5 cycles: the 5 writes complete in order.
- Burst of a 21×21 sprite (441 pixels) with mem_gnt toggling 1/0: all 441 writes occur in order, none are lost, and idle=1 afterwards.
- Clipping with PIXEL_CLIP_EN: plot (160,0), (0,120), (10,10). Only one write occurs, at mem_addr=1610, and drop_count=2. Without the macro: 3 writes, drop_count=0.
- Reset mid-operation: fill the FIFO with mem_gnt=0 and assert reset between edges. mem_we=0 immediately, then ready=1, idle=1 and drop_count=0. After release there are no writes until a new plot.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg -- shared framebuffer definitions used by the pixel writer and the
// drawing engines: screen geometry, address/colour widths, the packed pixel
// record and the coordinate-to-address helper.
package fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 3;

    typedef struct packed {
        logic [7:0]         x;
        logic [6:0]         y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // y*160 + x as two shifts and adds; result wraps to ADDR_W bits.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px,
                                                    input logic [6:0] py);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(py);
        return (yy << 7) + (yy << 5) + ADDR_W'(px);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo -- synchronous FIFO of pixel_t records.
// Ports:
//   clock, reset       : clock, async active-high reset (flushes pointers)
//   push, wdata        : write request / data (ignored when full)
//   pop, rdata         : read request / head entry (ignored when empty)
//   full, empty, count : occupancy status, all from registered count
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  pixel_t                 wdata,
    input  logic                   pop,
    output pixel_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    pixel_t          mem [DEPTH];
    logic   [PW-1:0] head;
    logic   [PW-1:0] tail;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[head];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= wdata;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer -- collects plotted pixels from the drawing engines into a
// small FIFO and turns them into framebuffer writes (addr = y*160 + x).
// Ports:
//   clock, reset          : clock, async active-high reset
//   x, y, color, plot     : pixel stream in; accepted when plot && ready
//   ready                 : FIFO not full
//   mem_addr, mem_data    : write address / colour, held until granted
//   mem_we, mem_gnt       : write request / arbiter grant
//   idle                  : FIFO and output stage both empty
//   drop_count            : saturating count of clipped pixels
// Build option: define PIXEL_CLIP_EN to discard off-screen pixels and count
// them in drop_count; otherwise every pixel is written and drop_count is 0.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         x,
    input  logic [6:0]         y,
    input  logic [COLOR_W-1:0] color,
    input  logic               plot,
    output logic               ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_we,
    input  logic               mem_gnt,
    output logic               idle,
    output logic [7:0]         drop_count
);

    pixel_t                 in_pix;
    pixel_t                 head_pix;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   accept;
    logic                   clipped;
    logic                   push;
    logic                   load;

    assign in_pix = '{x: x, y: y, color: color};
    assign accept = plot && ready;

`ifdef PIXEL_CLIP_EN
    assign clipped = (x >= 8'(SCREEN_W)) || (y >= 7'(SCREEN_H));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (accept && clipped && drop_count != 8'hff)
            drop_count <= drop_count + 1'b1;
    end
`else
    assign clipped    = 1'b0;
    assign drop_count = '0;
`endif

    // A clipped pixel still consumes the handshake but never enters the FIFO.
    assign push = accept && !clipped;

    // Refill the stage when it is empty or its write retires this edge.
    assign load = !fifo_empty && (!mem_we || mem_gnt);

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (in_pix),
        .pop   (load),
        .rdata (head_pix),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready = !fifo_full;
    assign idle  = (fifo_count == '0) && !mem_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (load) begin
            mem_we   <= 1'b1;
            mem_addr <= pix_addr(head_pix.x, head_pix.y);
            mem_data <= head_pix.color;
        end else if (mem_gnt) begin
            // Granted with nothing behind it: the stage empties.
            mem_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;
    import fb_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_gnt;
    logic        idle;
    logic [7:0]  drop_count;

    fb_pixel_writer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .ready      (ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_gnt    (mem_gnt),
        .idle       (idle),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   writes = 0;
    int   exp_drop = 0;
    exp_t q[$];
    int   wlog[$];

    // Reference model: every accepted on-screen pixel must later be written,
    // in order, at y*160+x (mod 2^15). Evaluated just before each edge.
    task automatic cycle();
        logic clip;
        exp_t e;
        clip = 1'b0;
        if (plot && ready) begin
`ifdef PIXEL_CLIP_EN
            clip = (x >= 8'd160) || (y >= 7'd120);
`endif
            if (clip) begin
                if (exp_drop < 255) exp_drop++;
            end else begin
                q.push_back('{addr: (int'(y) * 160 + int'(x)) % 32768, data: int'(color)});
            end
        end
        if (mem_we && mem_gnt) begin
            writes++;
            wlog.push_back(int'(mem_addr));
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected addr=%0d data=%0d required=none", mem_addr, mem_data);
            end else begin
                e = q.pop_front();
                if (mem_addr !== e.addr[14:0] || mem_data !== e.data[2:0]) begin
                    bad++;
                    $display("FAIL write_order addr=%0d data=%0d required addr=%0d data=%0d",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        plot    = 1'b0;
        mem_gnt = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (idle && q.size() == 0) break;
            cycle();
        end
        total++;
        if (!(idle && q.size() == 0)) begin
            bad++;
            $display("FAIL drain_timeout idle=%0b pending=%0d required idle=1 pending=0", idle, q.size());
        end
    endtask

    task automatic rand_pix();
        x     = 8'($urandom_range(0, 159));
        y     = 7'($urandom_range(0, 119));
        color = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        reset = 1'b1; plot = 1'b0; mem_gnt = 1'b0; x = '0; y = '0; color = '0;
        #12;
        reset = 1'b0;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            bad++;
            $display("FAIL reset_mem we=%0b addr=%0d data=%0d required 0/0/0", mem_we, mem_addr, mem_data);
        end
        total++;
        if (ready !== 1'b1 || idle !== 1'b1 || drop_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_status ready=%0b idle=%0b drop=%0d required 1/1/0", ready, idle, drop_count);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        x = 8'd5; y = 7'd2; color = 3'b101; plot = 1'b1; mem_gnt = 1'b1;
        cycle();
        plot = 1'b0;
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL single_early mem_we=%0b required 0", mem_we);
        end
        cycle();
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd325 || mem_data !== 3'd5) begin
            bad++;
            $display("FAIL single_write we=%0b addr=%0d data=%0d required 1/325/5", mem_we, mem_addr, mem_data);
        end
        cycle();
        total++;
        if (idle !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL single_idle idle=%0b we=%0b required 1/0", idle, mem_we);
        end
    endtask

    task automatic test_corner();
        int w0;
        w0 = writes;
        mem_gnt = 1'b1;
        x = 8'd159; y = 7'd119; color = 3'($urandom_range(0, 7)); plot = 1'b1;
        cycle();
        x = 8'd0; y = 7'd0; color = 3'($urandom_range(0, 7));
        cycle();
        drain();
        total++;
        if (writes - w0 != 2 || wlog[$-1] != 19199 || wlog[$] != 0) begin
            bad++;
            $display("FAIL corner_addr n=%0d a0=%0d a1=%0d required 2/19199/0",
                     writes - w0, wlog[$-1], wlog[$]);
        end
    endtask

    task automatic test_throughput();
        int lows;
        int w0;
        lows = 0;
        w0 = writes;
        mem_gnt = 1'b1;
        plot = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_pix();
            if (!ready) lows++;
            cycle();
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL throughput_ready low_cycles=%0d required 0", lows);
        end
        drain();
        total++;
        if (writes - w0 != 30) begin
            bad++;
            $display("FAIL throughput_count writes=%0d required 30", writes - w0);
        end
    endtask

    task automatic test_back_pressure();
        int acc;
        int first;
        int w0;
        acc = 0;
        first = -1;
        mem_gnt = 1'b0;
        plot = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_pix();
            if (ready) begin
                if (first < 0) first = int'(y) * 160 + int'(x);
                acc++;
            end
            cycle();
        end
        total++;
        if (acc != DEPTH + 1) begin
            bad++;
            $display("FAIL bp_accepted count=%0d required %0d", acc, DEPTH + 1);
        end
        total++;
        if (ready !== 1'b0 || mem_we !== 1'b1 || int'(mem_addr) != first) begin
            bad++;
            $display("FAIL bp_hold ready=%0b we=%0b addr=%0d required 0/1/%0d", ready, mem_we, mem_addr, first);
        end
        plot = 1'b0;
        mem_gnt = 1'b1;
        w0 = writes;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        total++;
        if (writes - w0 != DEPTH + 1 || idle !== 1'b1) begin
            bad++;
            $display("FAIL bp_release writes=%0d idle=%0b required %0d/1", writes - w0, idle, DEPTH + 1);
        end
    endtask

    task automatic test_burst();
        int sent;
        int w0;
        int x0;
        int y0;
        logic acc;
        sent = 0;
        w0 = writes;
        x0 = $urandom_range(0, 139);
        y0 = $urandom_range(0, 99);
        for (int cyc = 0; cyc < 5000 && sent < 441; cyc++) begin
            x = 8'(x0 + sent % 21);
            y = 7'(y0 + sent / 21);
            color = 3'($urandom_range(0, 7));
            plot = 1'b1;
            mem_gnt = cyc[0];
            acc = ready;
            cycle();
            if (acc) sent++;
        end
        total++;
        if (sent != 441) begin
            bad++;
            $display("FAIL burst_accept sent=%0d required 441", sent);
        end
        drain();
        total++;
        if (writes - w0 != 441 || idle !== 1'b1) begin
            bad++;
            $display("FAIL burst_writes writes=%0d idle=%0b required 441/1", writes - w0, idle);
        end
    endtask

    task automatic test_clip();
        int w0;
        int exp_n;
        int exp_d;
`ifdef PIXEL_CLIP_EN
        exp_n = 1; exp_d = 2;
`else
        exp_n = 3; exp_d = 0;
`endif
        w0 = writes;
        mem_gnt = 1'b1;
        plot = 1'b1; color = 3'd6;
        x = 8'd160; y = 7'd0;   cycle();
        x = 8'd0;   y = 7'd120; cycle();
        x = 8'd10;  y = 7'd10;  cycle();
        drain();
        total++;
        if (writes - w0 != exp_n || wlog[$] != 1610) begin
            bad++;
            $display("FAIL clip_writes n=%0d last=%0d required %0d/1610", writes - w0, wlog[$], exp_n);
        end
        total++;
        if (drop_count !== 8'(exp_d) || int'(drop_count) != exp_drop) begin
            bad++;
            $display("FAIL clip_drop drop=%0d required %0d", drop_count, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        mem_gnt = 1'b0;
        plot = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_pix();
            cycle();
        end
        plot = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_async mem_we=%0b required 0", mem_we);
        end
        total++;
        if (ready !== 1'b1 || idle !== 1'b1 || drop_count !== 8'd0) begin
            bad++;
            $display("FAIL rst_status ready=%0b idle=%0b drop=%0d required 1/1/0", ready, idle, drop_count);
        end
        q.delete();
        exp_drop = 0;
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        mem_gnt = 1'b1;
        w0 = writes;
        for (int i = 0; i < 6; i++) cycle();
        total++;
        if (writes - w0 != 0 || idle !== 1'b1) begin
            bad++;
            $display("FAIL rst_no_retry writes=%0d idle=%0b required 0/1", writes - w0, idle);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_throughput();
        test_back_pressure();
        test_burst();
        test_clip();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
